// File: rtl/elm_pkg.sv
// Shared types and constants for the ELM hidden-layer datapath.
package elm_pkg;

   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;
   localparam int ACC_W  = 32;
   localparam int LEN_W  = 10;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/elm_fxp_mul.sv
// Registered signed fixed-point multiply; the product is rescaled to the
// accumulator's format and tagged with a one-stage valid bit.
module elm_fxp_mul
   import elm_pkg::*;
#(
   parameter int DATA_W = elm_pkg::DATA_W,
   parameter int FRAC_W = elm_pkg::FRAC_W,
   parameter int ACC_W  = elm_pkg::ACC_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_valid,
   input  logic signed [DATA_W-1:0] i_x,
   input  logic signed [DATA_W-1:0] i_w,
   output logic signed [ACC_W-1:0]  o_prod,
   output logic                     o_valid
);

   logic signed [2*DATA_W-1:0] w_full;
   logic signed [2*DATA_W-1:0] w_shift;
   logic signed [ACC_W-1:0]    r_prod;
   logic                       r_valid;

   // Arithmetic shift floors toward minus infinity; the size cast sign-extends or truncates.
   assign w_full  = i_x * i_w;
   assign w_shift = w_full >>> FRAC_W;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prod  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_prod <= ACC_W'(w_shift);
         end
      end
   end

   assign o_prod  = r_prod;
   assign o_valid = r_valid;

endmodule

// File: rtl/elm_mac_sequencer.sv
// Feeds the ELM hidden-layer accumulator: clears it, streams len scaled
// products into it with saturation, and pulses done when the sum is final.
module elm_mac_sequencer
   import elm_pkg::*;
#(
   parameter int DATA_W = elm_pkg::DATA_W,
   parameter int FRAC_W = elm_pkg::FRAC_W,
   parameter int ACC_W  = elm_pkg::ACC_W,
   parameter int LEN_W  = elm_pkg::LEN_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [LEN_W-1:0]         len,
   output logic                     busy,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] x_in,
   input  logic signed [DATA_W-1:0] w_in,
   input  logic [ACC_W-1:0]         acc_q,
   output logic [ACC_W-1:0]         acc_d,
   output logic                     acc_load,
   output logic                     acc_clr,
   output logic                     done,
   output logic                     sat
);

   localparam logic [ACC_W-1:0] L_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] L_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t                  r_state;
   logic [LEN_W-1:0]        r_len;
   logic [LEN_W-1:0]        r_count;
   logic                    r_sat;
   logic                    w_accept;
   logic                    w_last;
   logic                    w_prod_v;
   logic                    w_ovf;
   logic signed [ACC_W-1:0] w_prod;
   logic [ACC_W:0]          w_sum;

   assign in_ready = (r_state == ST_RUN) && (r_count < r_len);
   assign w_accept = in_valid && in_ready;
   assign w_last   = (r_count == r_len - LEN_W'(1));

   elm_fxp_mul #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_accept),
      .i_x     (x_in),
      .i_w     (w_in),
      .o_prod  (w_prod),
      .o_valid (w_prod_v)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_len   <= '0;
         r_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_CLEAR;
                  r_len   <= len;
                  r_count <= '0;
               end
            end
            ST_CLEAR: r_state <= (r_len == '0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
               if (w_accept) begin
                  r_count <= r_count + LEN_W'(1);
                  if (w_last) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: r_state <= ST_DONE;
            ST_DONE:  r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   // The sticky flag belongs to one neuron, so only an accepted start wipes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat <= 1'b0;
      end else if (r_state == ST_IDLE && start) begin
         r_sat <= 1'b0;
      end else if (w_prod_v && w_ovf) begin
         r_sat <= 1'b1;
      end
   end

   assign w_sum = {acc_q[ACC_W-1], acc_q} + {w_prod[ACC_W-1], w_prod};
   assign w_ovf = (w_sum[ACC_W] != w_sum[ACC_W-1]);

   always_comb begin
      acc_d = '0;
      if (w_prod_v) begin
         if (!w_ovf) begin
            acc_d = w_sum[ACC_W-1:0];
         end else if (w_sum[ACC_W]) begin
            acc_d = L_ACC_MIN;
         end else begin
            acc_d = L_ACC_MAX;
         end
      end
   end

   assign acc_load = w_prod_v;
   assign acc_clr  = (r_state == ST_CLEAR);
   assign busy     = (r_state != ST_IDLE);
   assign done     = (r_state == ST_DONE);
   assign sat      = r_sat;

endmodule
